// File: rtl/hp_fpu_issue.sv
// Issue/response wrapper between the core and the hp_top half-precision FPU datapath.
// Optional sticky exception flags are enabled with the FPU_FLAGS_EN macro.
module hp_fpu_issue #(
    parameter int NUM_BITS   = 16,
    parameter int OP_WIDTH   = 3,
    parameter int FLAG_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_BITS-1:0]   req_a,
    input  logic [NUM_BITS-1:0]   req_b,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic                  flush,
    output logic [NUM_BITS-1:0]   fpu_src_a,
    output logic [NUM_BITS-1:0]   fpu_src_b,
    output logic [OP_WIDTH-1:0]   fpu_op,
    input  logic [NUM_BITS-1:0]   fpu_res,
    input  logic [FLAG_WIDTH-1:0] fpu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NUM_BITS-1:0]   rsp_result,
    output logic [FLAG_WIDTH-1:0] rsp_flags,
    input  logic                  fflags_clr,
    output logic [3:0]            fflags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    logic   req_ready_r;
    logic   accept_s;
    logic   capture_s;

    // flush blocks acceptance combinationally so a flushed request is never latched
    assign req_ready = req_ready_r & ~flush;
    assign accept_s  = (state_r == IDLE) & req_ready & req_valid;
    assign capture_s = (state_r == EXEC) & ~flush;

    // Issue FSM: operand latch, result capture and response handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= {NUM_BITS{1'b0}};
            rsp_flags   <= {FLAG_WIDTH{1'b0}};
            fpu_src_a   <= {NUM_BITS{1'b0}};
            fpu_src_b   <= {NUM_BITS{1'b0}};
            fpu_op      <= {OP_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        fpu_src_a   <= req_a;
                        fpu_src_b   <= req_b;
                        fpu_op      <= req_op;
                        state_r     <= EXEC;
                        req_ready_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end else begin
                        rsp_result  <= fpu_res;
                        rsp_flags   <= fpu_flags;
                        rsp_valid   <= 1'b1;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid   <= 1'b0;
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef FPU_FLAGS_EN
    // Exception-relevant subset {inf, subN, QNan, SNan} of the class flags
    function automatic logic [3:0] sticky_bits(input logic [FLAG_WIDTH-1:0] f);
        return {f[4], f[3], f[1], f[0]};
    endfunction

    // Sticky flags: a capture in the same cycle as a clear keeps only the new bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags <= 4'b0000;
        end else if (capture_s) begin
            if (fflags_clr) begin
                fflags <= sticky_bits(fpu_flags);
            end else begin
                fflags <= fflags | sticky_bits(fpu_flags);
            end
        end else if (fflags_clr) begin
            fflags <= 4'b0000;
        end else begin
            fflags <= fflags;
        end
    end
`else
    logic unused_s;
    assign unused_s = fflags_clr ^ capture_s;
    assign fflags   = 4'b0000;
`endif

endmodule

// File: tb/tb_hp_fpu_issue.sv
// Directed self-checking bench for hp_fpu_issue; the bench drives fpu_res/fpu_flags
// itself in place of hp_top, using hand-computed half-precision results.
module tb_hp_fpu_issue;

`ifdef FPU_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  req_op;
    logic        flush;
    logic [15:0] fpu_src_a;
    logic [15:0] fpu_src_b;
    logic [2:0]  fpu_op;
    logic [15:0] fpu_res;
    logic [5:0]  fpu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [5:0]  rsp_flags;
    logic        fflags_clr;
    logic [3:0]  fflags;

    int total_cnt;
    int fail_cnt;
    logic [3:0] exp_ff;

    hp_fpu_issue #(.NUM_BITS(16), .OP_WIDTH(3), .FLAG_WIDTH(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .flush(flush),
        .fpu_src_a(fpu_src_a), .fpu_src_b(fpu_src_b), .fpu_op(fpu_op),
        .fpu_res(fpu_res), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .fflags_clr(fflags_clr), .fflags(fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv)
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        total_cnt  = 0;
        fail_cnt   = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        req_op     = 3'b000;
        flush      = 1'b0;
        fpu_res    = 16'h0000;
        fpu_flags  = 6'b000000;
        rsp_ready  = 1'b0;
        fflags_clr = 1'b0;
        exp_ff     = 4'b0000;

        // reset values
        step();
        step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk("rst_rsp_flags", {26'd0, rsp_flags}, 32'd0);
        chk("rst_src_a", {16'd0, fpu_src_a}, 32'd0);
        chk("rst_fflags", {28'd0, fflags}, 32'd0);
        reset = 1'b1;
        step();
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // 1.0 * 2.0 = 2.0, normal result
        req_valid = 1'b1; req_a = 16'h3C00; req_b = 16'h4000; req_op = 3'b100;
        rsp_ready = 1'b1; fpu_res = 16'h4000; fpu_flags = 6'b000100;
        step();
        req_valid = 1'b0;
        chk("mul_src_a", {16'd0, fpu_src_a}, 32'h3C00);
        chk("mul_src_b", {16'd0, fpu_src_b}, 32'h4000);
        chk("mul_op", {29'd0, fpu_op}, 32'd4);
        chk("mul_exec_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mul_exec_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("mul_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mul_rsp_result", {16'd0, rsp_result}, 32'h4000);
        chk("mul_rsp_flags", {26'd0, rsp_flags}, 32'b000100);
        step();
        chk("mul_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mul_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("mul_fflags", {28'd0, fflags}, 32'd0);

        // +inf + 1.0 = +inf with a 5-cycle response stall
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_a = 16'h7C00; req_b = 16'h3C00; req_op = 3'b000;
        fpu_res = 16'h7C00; fpu_flags = 6'b010000;
        step();
        req_a = 16'h1111;
        step();
        fpu_res = 16'h1234; fpu_flags = 6'b000001;
        exp_ff = FLAGS_EN ? 4'b1000 : 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_result", {16'd0, rsp_result}, 32'h7C00);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        chk("stall_src_a", {16'd0, fpu_src_a}, 32'h7C00);
        chk("inf_fflags", {28'd0, fflags}, {28'd0, exp_ff});
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        chk("stall_release", {31'd0, rsp_valid}, 32'd0);

        // back-to-back with req_valid held: accepts three edges apart
        req_valid = 1'b1; req_a = 16'h0001; fpu_res = 16'h0001; fpu_flags = 6'b000100;
        step();
        chk("b2b_first_a", {16'd0, fpu_src_a}, 32'h0001);
        req_a = 16'h0002;
        step();
        chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
        step();
        chk("b2b_hs_src", {16'd0, fpu_src_a}, 32'h0001);
        chk("b2b_hs_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("b2b_second_a", {16'd0, fpu_src_a}, 32'h0002);
        chk("b2b_second_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        step();
        chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
        step();
        chk("b2b_done", {31'd0, rsp_valid}, 32'd0);

        // flush in EXEC: no response, fflags untouched
        req_valid = 1'b1; req_a = 16'h5555; req_op = 3'b010; fpu_flags = 6'b000001;
        step();
        req_valid = 1'b0; flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
        chk("flush_fflags", {28'd0, fflags}, {28'd0, exp_ff});
        chk("flush_gated_ready", {31'd0, req_ready}, 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("flush_no_pulse", {31'd0, rsp_valid}, 32'd0);
        // flush in IDLE drops the request
        req_valid = 1'b1; req_a = 16'h6666; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_drop_src", {16'd0, fpu_src_a}, 32'h5555);
        step();
        chk("flush_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("flush_drop_ready", {31'd0, req_ready}, 32'd1);

        // QNaN result with clear on the capture edge: new bits win
        req_valid = 1'b1; req_a = 16'h7E00; req_b = 16'h3C00; req_op = 3'b100;
        fpu_res = 16'h7E00; fpu_flags = 6'b000010; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0; fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        exp_ff = FLAGS_EN ? 4'b0010 : 4'b0000;
        chk("qnan_result", {16'd0, rsp_result}, 32'h7E00);
        chk("qnan_fflags", {28'd0, fflags}, {28'd0, exp_ff});
        rsp_ready = 1'b1;
        step();
        chk("qnan_hold", {28'd0, fflags}, {28'd0, exp_ff});
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_alone", {28'd0, fflags}, 32'd0);

        // reset asserted mid-EXEC
        req_valid = 1'b1; req_a = 16'h1357; fpu_flags = 6'b010000;
        step();
        req_valid = 1'b0;
        chk("pre_rst_src", {16'd0, fpu_src_a}, 32'h1357);
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_src", {16'd0, fpu_src_a}, 32'd0);
        chk("midrst_fflags", {28'd0, fflags}, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("postrst_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("postrst_valid", {31'd0, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
